// File: rtl/eeprom_page_ctrl.sv
// Command-level front end for the EEPROM I2C byte driver: splits a user read/write
// command into page-aligned (write) or 64-byte (read) bursts and waits tWR after every page.
module eeprom_page_ctrl #(
    parameter int PAGE_SIZE  = 32,
    parameter int TWR_CYCLES = 250000,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len_sub1,
    input  logic [7:0]        usr_wr_data,
    output logic              usr_wr_rden,
    output logic [7:0]        usr_rd_data,
    output logic              usr_rd_valid,
    output logic              cmd_done,
    output logic              drv_wr_req,
    output logic [23:0]       drv_wr_addr,
    output logic [5:0]        drv_wr_num_sub1,
    output logic [7:0]        drv_wr_data,
    input  logic              drv_wr_rden,
    input  logic              drv_wr_busy,
    output logic              drv_rd_req,
    output logic [23:0]       drv_rd_addr,
    output logic [5:0]        drv_rd_num_sub1,
    input  logic [7:0]        drv_rd_data,
    input  logic              drv_rd_valid,
    input  logic              drv_rd_busy
);

    localparam int TWR_W  = $clog2(TWR_CYCLES + 1);
    localparam int PAGE_B = $clog2(PAGE_SIZE);
    localparam int REM_W  = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_BUSY,
        S_TWR,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [REM_W-1:0]  rem_reg;
    logic              rw_reg;
    logic [6:0]        n_reg;
    logic [TWR_W-1:0]  twr_cnt_reg;
    logic [ADDR_W-1:0] wr_addr_reg, rd_addr_reg;
    logic [5:0]        wr_num_reg, rd_num_reg;
    logic [7:0]        rd_data_reg;
    logic              rd_valid_reg;

    logic [PAGE_B-1:0] page_off;
    logic [6:0]        page_room;
    logic [6:0]        burst_limit;
    logic [6:0]        burst_n;
    logic [REM_W-1:0]  rem_after;
    logic              busy_sel;
    logic              twr_last;
    logic              in_busy;

    // Writes may not cross a page boundary; reads are only capped by the driver's 64-byte limit.
    assign page_off    = addr_reg[PAGE_B-1:0];
    assign page_room   = 7'(PAGE_SIZE) - 7'(page_off);
    assign burst_limit = rw_reg ? 7'd64 : page_room;
    assign burst_n     = (rem_reg < REM_W'(burst_limit)) ? 7'(rem_reg) : burst_limit;
    assign rem_after   = rem_reg - REM_W'(n_reg);
    assign busy_sel    = rw_reg ? drv_rd_busy : drv_wr_busy;
    assign twr_last    = (twr_cnt_reg == TWR_W'(TWR_CYCLES - 1));
    assign in_busy     = (state_reg == S_BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        cmd_done   = 1'b0;
        drv_wr_req = 1'b0;
        drv_rd_req = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: state_next = S_REQ;
            S_REQ: begin
                drv_wr_req = !rw_reg;
                drv_rd_req = rw_reg;
                if (busy_sel) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!busy_sel) begin
                    if (!rw_reg) begin
                        state_next = S_TWR;
                    end else if (rem_after != '0) begin
                        state_next = S_CALC;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_TWR: begin
                if (twr_last) begin
                    state_next = (rem_reg != '0) ? S_CALC : S_DONE;
                end
            end
            S_DONE: begin
                cmd_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            rem_reg      <= '0;
            rw_reg       <= 1'b0;
            n_reg        <= '0;
            twr_cnt_reg  <= '0;
            wr_addr_reg  <= '0;
            rd_addr_reg  <= '0;
            wr_num_reg   <= '0;
            rd_num_reg   <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && cmd_valid) begin
                addr_reg <= cmd_addr;
                rem_reg  <= REM_W'(cmd_len_sub1) + REM_W'(1);
                rw_reg   <= cmd_rw;
            end
            if (state_reg == S_CALC) begin
                n_reg <= burst_n;
                if (rw_reg) begin
                    rd_addr_reg <= addr_reg;
                    rd_num_reg  <= 6'(burst_n - 7'd1);
                end else begin
                    wr_addr_reg <= addr_reg;
                    wr_num_reg  <= 6'(burst_n - 7'd1);
                end
            end
            // Address wraps naturally at 2^ADDR_W, so the next page split sees the wrapped address.
            if (in_busy && !busy_sel) begin
                addr_reg <= addr_reg + ADDR_W'(n_reg);
                rem_reg  <= rem_after;
            end
            twr_cnt_reg  <= (state_reg == S_TWR) ? twr_cnt_reg + TWR_W'(1) : '0;
            rd_valid_reg <= in_busy && rw_reg && drv_rd_valid;
            if (in_busy && rw_reg && drv_rd_valid) begin
                rd_data_reg <= drv_rd_data;
            end
        end
    end

    assign usr_wr_rden     = drv_wr_rden && in_busy && !rw_reg;
    assign drv_wr_data     = usr_wr_data;
    assign usr_rd_data     = rd_data_reg;
    assign usr_rd_valid    = rd_valid_reg;
    assign drv_wr_addr     = 24'(wr_addr_reg);
    assign drv_rd_addr     = 24'(rd_addr_reg);
    assign drv_wr_num_sub1 = wr_num_reg;
    assign drv_rd_num_sub1 = rd_num_reg;

endmodule

// File: tb/tb_eeprom_page_ctrl.sv
// Randomized scoreboard bench for eeprom_page_ctrl with a behavioural I2C driver model
// and a user-side FWFT byte source.
module tb_eeprom_page_ctrl;

    localparam int PAGE_SIZE  = 32;
    localparam int TWR_CYCLES = 20;
    localparam int ADDR_W     = 16;
    localparam int LEN_W      = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_rw = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len_sub1 = '0;
    logic [7:0]        usr_wr_data;
    logic              usr_wr_rden;
    logic [7:0]        usr_rd_data;
    logic              usr_rd_valid;
    logic              cmd_done;
    logic              drv_wr_req;
    logic [23:0]       drv_wr_addr;
    logic [5:0]        drv_wr_num_sub1;
    logic [7:0]        drv_wr_data;
    logic              drv_wr_rden = 1'b0;
    logic              drv_wr_busy = 1'b0;
    logic              drv_rd_req;
    logic [23:0]       drv_rd_addr;
    logic [5:0]        drv_rd_num_sub1;
    logic [7:0]        drv_rd_data = '0;
    logic              drv_rd_valid = 1'b0;
    logic              drv_rd_busy = 1'b0;

    always #5 clk = ~clk;

    eeprom_page_ctrl #(
        .PAGE_SIZE (PAGE_SIZE),
        .TWR_CYCLES(TWR_CYCLES),
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rw         (cmd_rw),
        .cmd_addr       (cmd_addr),
        .cmd_len_sub1   (cmd_len_sub1),
        .usr_wr_data    (usr_wr_data),
        .usr_wr_rden    (usr_wr_rden),
        .usr_rd_data    (usr_rd_data),
        .usr_rd_valid   (usr_rd_valid),
        .cmd_done       (cmd_done),
        .drv_wr_req     (drv_wr_req),
        .drv_wr_addr    (drv_wr_addr),
        .drv_wr_num_sub1(drv_wr_num_sub1),
        .drv_wr_data    (drv_wr_data),
        .drv_wr_rden    (drv_wr_rden),
        .drv_wr_busy    (drv_wr_busy),
        .drv_rd_req     (drv_rd_req),
        .drv_rd_addr    (drv_rd_addr),
        .drv_rd_num_sub1(drv_rd_num_sub1),
        .drv_rd_data    (drv_rd_data),
        .drv_rd_valid   (drv_rd_valid),
        .drv_rd_busy    (drv_rd_busy)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Scoreboard queues: burst = {rw, addr[15:0], num_sub1[5:0]}
    logic [22:0] exp_burst_q[$];
    logic [7:0]  exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];

    // User FWFT write-byte source
    logic [7:0]  wbuf [0:4095];
    logic [11:0] widx = '0;
    logic [11:0] wr_head = '0;
    logic        fifo_flush = 1'b0;
    assign usr_wr_data = wbuf[widx];
    always @(posedge clk) begin
        if (fifo_flush) widx <= wr_head;
        else if (usr_wr_rden) widx <= widx + 12'd1;
    end

    // Monitor: burst requests, read bytes, pulse counts
    int   rden_cnt = 0;
    int   rdv_cnt = 0;
    int   done_cnt = 0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req <= 1'b0;
        end else begin
            prev_req <= drv_wr_req | drv_rd_req;
            if (drv_wr_req | drv_rd_req) check("one_req", 32'(drv_wr_req & drv_rd_req), 32'd0);
            if ((drv_wr_req | drv_rd_req) && !prev_req) begin
                if (exp_burst_q.size() == 0) begin
                    fail_now("burst_unexpected", "request with no expected burst");
                end else begin
                    logic [22:0] e;
                    e = exp_burst_q.pop_front();
                    $display("burst rw=%0d addr=0x%06h sub1=%0d", drv_rd_req,
                             drv_rd_req ? drv_rd_addr : drv_wr_addr,
                             drv_rd_req ? drv_rd_num_sub1 : drv_wr_num_sub1);
                    check("burst_rw", 32'(drv_rd_req), 32'(e[22]));
                    check("burst_addr", 32'(drv_rd_req ? drv_rd_addr : drv_wr_addr), 32'(e[21:6]));
                    check("burst_sub1", 32'(drv_rd_req ? drv_rd_num_sub1 : drv_wr_num_sub1), 32'(e[5:0]));
                end
            end
            if (usr_rd_valid) begin
                rdv_cnt <= rdv_cnt + 1;
                if (exp_rd_q.size() == 0) fail_now("rd_unexpected", "usr_rd_valid with no byte pending");
                else check("rd_data", 32'(usr_rd_data), 32'(exp_rd_q.pop_front()));
            end
            if (usr_wr_rden) rden_cnt <= rden_cnt + 1;
            if (cmd_done) done_cnt <= done_cnt + 1;
        end
    end

    // Behavioural I2C driver: busy handshake, byte pulses, then measures the idle gap
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (drv_wr_req || drv_rd_req)) begin
                bit is_rd;
                int n;
                int g;
                is_rd = drv_rd_req;
                n = is_rd ? int'(drv_rd_num_sub1) + 1 : int'(drv_wr_num_sub1) + 1;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (is_rd) drv_rd_busy = 1'b1;
                else drv_wr_busy = 1'b1;
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    if (is_rd) begin
                        drv_rd_data = 8'($urandom);
                        exp_rd_q.push_back(drv_rd_data);
                        drv_rd_valid = 1'b1;
                    end else begin
                        if (exp_wr_q.size() == 0) fail_now("wr_unexpected", "driver consumed an extra byte");
                        else check("wr_data", 32'(drv_wr_data), 32'(exp_wr_q.pop_front()));
                        drv_wr_rden = 1'b1;
                    end
                    @(negedge clk);
                    drv_rd_valid = 1'b0;
                    drv_wr_rden = 1'b0;
                end
                drv_rd_busy = 1'b0;
                drv_wr_busy = 1'b0;
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (rst_n && !cmd_done && !drv_wr_req && !drv_rd_req && g < 200);
                if (rst_n) begin
                    if (is_rd) check("rd_gap_short", 32'(g <= 3), 32'd1);
                    else check("wr_gap_twr", 32'(g >= TWR_CYCLES), 32'd1);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        check("rst_reqs", 32'({drv_wr_req, drv_rd_req}), 32'd0);
        check("rst_wr_addr", 32'(drv_wr_addr), 32'd0);
        check("rst_rd_addr", 32'(drv_rd_addr), 32'd0);
        check("rst_nums", 32'({drv_wr_num_sub1, drv_rd_num_sub1}), 32'd0);
        check("rst_pulses", 32'({usr_wr_rden, usr_rd_valid}), 32'd0);
        check("rst_rd_data", 32'(usr_rd_data), 32'd0);
    endtask

    // mode 0: normal, 1: cmd_valid pulsed during write BUSY, 2: reset during tWR
    task automatic run_cmd(input bit rw, input logic [15:0] addr, input int len_sub1, input int mode);
        int rem;
        int a;
        int n;
        int t;
        int base_rden;
        int base_rdv;
        int base_done;
        rem = len_sub1 + 1;
        a = int'(addr);
        while (rem > 0) begin
            n = rw ? 64 : PAGE_SIZE - (a % PAGE_SIZE);
            if (rem < n) n = rem;
            exp_burst_q.push_back({rw, 16'(a), 6'(n - 1)});
            a = (a + n) % 65536;
            rem -= n;
        end
        if (!rw) begin
            for (int i = 0; i <= len_sub1; i++) begin
                wbuf[wr_head] = 8'($urandom);
                exp_wr_q.push_back(wbuf[wr_head]);
                wr_head = wr_head + 12'd1;
            end
        end
        @(negedge clk);
        base_rden = rden_cnt;
        base_rdv = rdv_cnt;
        base_done = done_cnt;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_rw = rw;
        cmd_addr = addr;
        cmd_len_sub1 = LEN_W'(len_sub1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (mode == 1) begin
            t = 0;
            while (!drv_wr_busy && t < 500) begin @(negedge clk); t++; end
            check("inj_busy_seen", 32'(drv_wr_busy), 32'd1);
            for (int i = 0; i < 5; i++) begin
                cmd_valid = 1'b1;
                cmd_rw = 1'($urandom);
                cmd_addr = 16'($urandom);
                @(negedge clk);
                check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            end
            cmd_valid = 1'b0;
        end
        if (mode == 2) begin
            t = 0;
            while (!drv_wr_busy && t < 500) begin @(negedge clk); t++; end
            while (drv_wr_busy && t < 1000) begin @(negedge clk); t++; end
            check("twr_reached", 32'(t < 1000), 32'd1);
            repeat (5) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            check_reset_outputs();
            rst_n = 1'b1;
            exp_burst_q.delete();
            exp_wr_q.delete();
            fifo_flush = 1'b1;
            @(negedge clk);
            fifo_flush = 1'b0;
            repeat (40) @(negedge clk);
            check("no_done_after_rst", 32'(done_cnt - base_done), 32'd0);
            $display("cmd rw=%0d addr=0x%04h len_sub1=%0d reset in tWR", rw, addr, len_sub1);
            return;
        end
        t = 0;
        while (!cmd_done && t < 20000) begin @(negedge clk); t++; end
        check("done_in_time", 32'(t < 20000), 32'd1);
        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt - base_done), 32'd1);
        check("rden_count", 32'(rden_cnt - base_rden), rw ? 32'd0 : 32'(len_sub1 + 1));
        check("rdvalid_count", 32'(rdv_cnt - base_rdv), rw ? 32'(len_sub1 + 1) : 32'd0);
        check("bursts_left", 32'(exp_burst_q.size()), 32'd0);
        check("bytes_left", 32'(exp_wr_q.size() + exp_rd_q.size()), 32'd0);
        $display("cmd rw=%0d addr=0x%04h len_sub1=%0d done", rw, addr, len_sub1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(1'b0, 16'h001C, 9, 0);
        run_cmd(1'b0, 16'h0040, 31, 0);
        run_cmd(1'b1, 16'h0000, 149, 0);
        run_cmd(1'b0, 16'hFFFE, 3, 0);
        for (int k = 0; k < 10; k++) begin
            logic [15:0] ra;
            ra = 16'($urandom);
            if (k % 3 == 0) ra[4:0] = 5'(PAGE_SIZE - $urandom_range(1, 4));
            run_cmd(1'($urandom), ra, $urandom_range(0, 120), 0);
        end
        run_cmd(1'b0, 16'($urandom), 40, 1);
        run_cmd(1'b0, 16'h001C, 9, 2);
        run_cmd(1'b1, 16'hFFF0, 70, 0);
        run_cmd(1'b0, 16'hFFE5, 20, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
